multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV64 subset datapath: R-format, ld, sd, beq, addi/slti. It sequences one shared ALU, one unified instruction/data memory port, the IR, PC and register file over several cycles per instruction. Control outputs are Moore (a function of the state, plus mem_ready_i/zero_i where stated). Instruction memory and data memory share one port with a ready handshake.

Parameters:
OP_W, 7, opcode width (instr_op_i)
STATE_W, 4, state register width

Ports:
clk_i  in  1  clock, all flops rising-edge
rst_i  in  1  synchronous active-high reset
instr_op_i  in  OP_W  opcode field of IR (valid from DECODE onward)
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory access completes this cycle
PCWrite_o  out  1  PC register load
IRWrite_o  out  1  IR and OldPC load
IorD_o  out  1  memory address select: 0=PC, 1=ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
MemtoReg_o  out  1  writeback select: 0=ALUOut, 1=MDR
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0=OldPC/PC, 1=rs1
ALUSrcB_o  out  2  00=rs2, 01=const 4, 10=immediate
ALU_op_o  out  2  00=add, 01=sub/compare, 10=use funct fields
PCSource_o  out  1  0=ALU result, 1=ALUOut (branch target)
illegal_o  out  1  sticky unsupported-opcode flag
state_o  out  STATE_W  current state, debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, TRAP=11.
- Reset:
  - On a clock edge with rst_i=1, state goes to IDLE and illegal_o clears.
  - In IDLE every output is 0.
  - IDLE always goes to FETCH.
  - Reset mid-instruction aborts at that edge, including a pending memory access or write.
- Default: any output not listed for a state is 0. No x is ever driven.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=00, PCSource=0.
  - IRWrite=PCWrite=mem_ready_i.
  - Stays in FETCH while mem_ready_i=0; goes to DECODE when it is 1.
- DECODE:
  - ALUSrcA=0 (OldPC), ALUSrcB=10, ALU_op=00; branch target latched into ALUOut.
  - Next state by opcode: 0110011→EXEC_R, 0010011→EXEC_I, 0000011/0100011→ADDR, 1100011→BRANCH, other→TRAP.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_op=10; goes to WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALU_op=10 (funct3 selects add/slt); goes to WB_ALU.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=00; ld→MEM_RD, sd→MEM_WR (opcode re-sampled from IR).
- MEM_RD: MemRead=1, IorD=1; waits on mem_ready_i, then goes to WB_MEM.
- MEM_WR: MemWrite=1, IorD=1; waits on mem_ready_i, then goes to FETCH.
- WB_ALU: RegWrite=1, MemtoReg=0; goes to FETCH.
- WB_MEM: RegWrite=1, MemtoReg=1; goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=01, PCSource=1, PCWrite=zero_i; goes to FETCH.
- TRAP: illegal_o=1. Holds TRAP until reset; no writes are issued.
- Latency with zero wait states (each wait cycle adds 1):
  - beq 3 cycles; R-format, addi and sd 4 cycles; ld 5 cycles.
  - First FETCH is 1 cycle after reset deasserts.
- MemRead/MemWrite stay asserted with a stable IorD for the whole wait. They are never both high.

Optional Feature:
PERF_CNT_EN
- Defined: adds ports cycle_cnt_o (out, 32) and instret_cnt_o (out, 32), both cleared by rst_i.
  - cycle_cnt_o increments every non-IDLE, non-TRAP cycle.
  - instret_cnt_o increments on each transition into FETCH from a completing state (WB_ALU, WB_MEM, MEM_WR with ready, BRANCH).
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package multicycle_pkg holds:
  - opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH);
  - the state enum;
  - ALU_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - ALUSrcB encodings.
- One sub-module, multicycle_ctrl_outdec: a purely combinational map from state, mem_ready_i and zero_i to the control outputs. The top module holds the state register and next-state logic.

Test Plan:
- Reset held 3 cycles, then released → cycle 0 IDLE with all outputs 0; cycle 1 FETCH with MemRead=1; illegal_o=0.
- R-format (0110011) with mem_ready_i=1 → states FETCH, DECODE, EXEC_R, WB_ALU; RegWrite=1 only in WB_ALU; back in FETCH at cycle 5.
- ld (0000011) with mem_ready_i low for 2 cycles in MEM_RD → MemRead=1 and IorD=1 held 3 cycles; WB_MEM with MemtoReg=1; 7 cycles total.
- beq (1100011): zero_i=1 → PCWrite=1 and PCSource=1 in BRANCH; zero_i=0 → PCWrite=0; both return to FETCH.
- Opcode 1111111 → TRAP, illegal_o=1 sticky for 10+ cycles, no Mem or Reg writes; rst_i pulse → IDLE and illegal_o=0.
- rst_i asserted during MEM_WR wait → next cycle IDLE and MemWrite=0; with PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared constants for the multi-cycle RV64-subset control FSM.
package multicycle_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  // Opcode field values recognised by the controller
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  // FSM state encodings (also visible on state_o for debug)
  localparam logic [STATE_W-1:0] S_IDLE   = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH  = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd2;
  localparam logic [STATE_W-1:0] S_EXEC_R = 4'd3;
  localparam logic [STATE_W-1:0] S_EXEC_I = 4'd4;
  localparam logic [STATE_W-1:0] S_ADDR   = 4'd5;
  localparam logic [STATE_W-1:0] S_MEM_RD = 4'd6;
  localparam logic [STATE_W-1:0] S_MEM_WR = 4'd7;
  localparam logic [STATE_W-1:0] S_WB_ALU = 4'd8;
  localparam logic [STATE_W-1:0] S_WB_MEM = 4'd9;
  localparam logic [STATE_W-1:0] S_BRANCH = 4'd10;
  localparam logic [STATE_W-1:0] S_TRAP   = 4'd11;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Moore output decoder: maps the current state (plus mem_ready/zero where
// the handshake or branch outcome matters) onto the datapath controls.
module multicycle_ctrl_outdec
  import multicycle_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic               mem_ready_i,
  input  logic               zero_i,
  output logic               PCWrite_o,
  output logic               IRWrite_o,
  output logic               IorD_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic               RegWrite_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic [1:0]         ALU_op_o,
  output logic               PCSource_o
);

  // Control decode; every output defaults to 0 so unlisted states are inert
  always_comb begin
    PCWrite_o  = 1'b0;
    IRWrite_o  = 1'b0;
    IorD_o     = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    RegWrite_o = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = SRCB_RS2;
    ALU_op_o   = ALUOP_ADD;
    PCSource_o = 1'b0;
    case (state_i)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        // PC+4 and IR are only committed on the cycle the read completes
        PCWrite_o = mem_ready_i;
        IRWrite_o = mem_ready_i;
      end
      S_DECODE: begin
        ALUSrcB_o = SRCB_IMM;
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        ALU_op_o  = ALUOP_FUNCT;
      end
      S_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_WB_ALU: begin
        RegWrite_o = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o  = 1'b1;
        ALU_op_o   = ALUOP_SUB;
        PCSource_o = 1'b1;
        PCWrite_o  = zero_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV64 subset (R-format, ld, sd, beq,
// addi/slti). Holds the state register and next-state logic; control
// outputs come from multicycle_ctrl_outdec.
// Optional build macro PERF_CNT_EN adds cycle_cnt_o / instret_cnt_o.
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               PCWrite_o,
  output logic               IRWrite_o,
  output logic               IorD_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic               RegWrite_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic [1:0]         ALU_op_o,
  output logic               PCSource_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   instret_cnt_o
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_q;

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:           state_d = S_EXEC_R;
          OP_ITYPE:           state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR: begin
        // Opcode is re-read from IR here rather than carried from DECODE
        if (instr_op_i == OP_LOAD)       state_d = S_MEM_RD;
        else if (instr_op_i == OP_STORE) state_d = S_MEM_WR;
        else                             state_d = S_TRAP;
      end
      S_MEM_RD: state_d = mem_ready_i ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_WB_ALU: state_d = S_FETCH;
      S_WB_MEM: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  multicycle_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready_i),
    .zero_i      (zero_i),
    .PCWrite_o   (PCWrite_o),
    .IRWrite_o   (IRWrite_o),
    .IorD_o      (IorD_o),
    .MemRead_o   (MemRead_o),
    .MemWrite_o  (MemWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .RegWrite_o  (RegWrite_o),
    .ALUSrcA_o   (ALUSrcA_o),
    .ALUSrcB_o   (ALUSrcB_o),
    .ALU_op_o    (ALU_op_o),
    .PCSource_o  (PCSource_o)
  );

  assign illegal_o = illegal_q;
  assign state_o   = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;
  logic             busy_c, retire_c;

  // An instruction retires on the edge that returns the FSM to FETCH
  always_comb begin
    busy_c   = (state_q != S_IDLE) && (state_q != S_TRAP);
    retire_c = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
               (state_q == S_BRANCH) || ((state_q == S_MEM_WR) && mem_ready_i);
  end

  // Free-running performance counters, wrapping modulo 2^32
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (busy_c)   cycle_cnt_q   <= cycle_cnt_q + CNT_W'(1);
      if (retire_c) instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each step drives inputs and pushes
// the expected control word; the word is popped and compared mid-cycle.
module tb_multicycle_ctrl;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
                         EXEC_I = 4'd4, ADDR = 4'd5, MEM_RD = 4'd6, MEM_WR = 4'd7,
                         WB_ALU = 4'd8, WB_MEM = 4'd9, BRANCH = 4'd10, TRAP = 4'd11;

  localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011, LD = 7'b0000011,
                         SD = 7'b0100011, BEQ = 7'b1100011, BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, iord, mr, mw, m2r, rw, srca;
    logic [1:0] srcb, aluop;
    logic       pcs, ill;
`ifdef PERF_CNT_EN
    logic [31:0] cyc, ret;
`endif
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic       rdy, z;
    logic [3:0] st;
  } step_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [6:0]  instr_op_i = '0;
  logic        zero_i = 1'b0, mem_ready_i = 1'b0;
  logic        PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, MemtoReg_o;
  logic        RegWrite_o, ALUSrcA_o, PCSource_o, illegal_o;
  logic [1:0]  ALUSrcB_o, ALU_op_o;
  logic [3:0]  state_o;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_o, instret_cnt_o;
`endif

  int unsigned n_checks = 0, n_pass = 0;
  exp_t        sb_q[$];
  logic [31:0] m_cyc = '0, m_ret = '0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o),
    .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o), .PCSource_o(PCSource_o),
    .illegal_o(illegal_o), .state_o(state_o)
`ifdef PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o)
`endif
  );

  // Expected control word for a state, written from the control table
  function automatic exp_t model(logic [3:0] st, logic rdy, logic z);
    exp_t e;
    e = '0;
    e.st = st;
    case (st)
      FETCH:  begin e.mr = 1; e.srcb = 2'b01; e.pcw = rdy; e.irw = rdy; end
      DECODE: e.srcb = 2'b10;
      EXEC_R: begin e.srca = 1; e.aluop = 2'b10; end
      EXEC_I: begin e.srca = 1; e.srcb = 2'b10; e.aluop = 2'b10; end
      ADDR:   begin e.srca = 1; e.srcb = 2'b10; end
      MEM_RD: begin e.mr = 1; e.iord = 1; end
      MEM_WR: begin e.mw = 1; e.iord = 1; end
      WB_ALU: e.rw = 1;
      WB_MEM: begin e.rw = 1; e.m2r = 1; end
      BRANCH: begin e.srca = 1; e.aluop = 2'b01; e.pcs = 1; e.pcw = z; end
      TRAP:   e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.st = state_o; o.pcw = PCWrite_o; o.irw = IRWrite_o; o.iord = IorD_o;
    o.mr = MemRead_o; o.mw = MemWrite_o; o.m2r = MemtoReg_o; o.rw = RegWrite_o;
    o.srca = ALUSrcA_o; o.srcb = ALUSrcB_o; o.aluop = ALU_op_o;
    o.pcs = PCSource_o; o.ill = illegal_o;
`ifdef PERF_CNT_EN
    o.cyc = cycle_cnt_o; o.ret = instret_cnt_o;
`endif
    return o;
  endfunction

  function automatic step_t mk(logic rst, logic [6:0] op, logic rdy, logic z, logic [3:0] st);
    step_t s;
    s.rst = rst; s.op = op; s.rdy = rdy; s.z = z; s.st = st;
    return s;
  endfunction

  // Drive one cycle of stimulus and push its expected outputs
  task automatic drive(step_t s);
    exp_t e;
    rst_i = s.rst; instr_op_i = s.op; mem_ready_i = s.rdy; zero_i = s.z;
    e = model(s.st, s.rdy, s.z);
`ifdef PERF_CNT_EN
    e.cyc = m_cyc; e.ret = m_ret;
`endif
    sb_q.push_back(e);
    if (s.rst) begin
      m_cyc = '0; m_ret = '0;
    end else begin
      if (s.st != IDLE && s.st != TRAP) m_cyc = m_cyc + 32'd1;
      if (s.st == WB_ALU || s.st == WB_MEM || s.st == BRANCH || (s.st == MEM_WR && s.rdy))
        m_ret = m_ret + 32'd1;
    end
  endtask

  task automatic test_reset();
    step_t seq[$];
    exp_t  e, o;
    rst_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    m_cyc = '0; m_ret = '0;
    seq.push_back(mk(0, RTYPE, 1, 1, IDLE));
    seq.push_back(mk(0, RTYPE, 0, 0, FETCH));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL reset step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_rtype();
    step_t seq[$];
    exp_t  e, o;
    seq = '{mk(0, RTYPE, 1, 0, FETCH), mk(0, RTYPE, 0, 0, DECODE), mk(0, RTYPE, 0, 0, EXEC_R),
            mk(0, RTYPE, 0, 0, WB_ALU), mk(0, RTYPE, 0, 0, FETCH)};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL rtype step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_addi();
    step_t seq[$];
    exp_t  e, o;
    seq = '{mk(0, ITYPE, 1, 1, FETCH), mk(0, ITYPE, 1, 1, DECODE), mk(0, ITYPE, 1, 1, EXEC_I),
            mk(0, ITYPE, 1, 1, WB_ALU), mk(0, ITYPE, 0, 0, FETCH)};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL addi step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_load_wait();
    step_t seq[$];
    exp_t  e, o;
    seq = '{mk(0, LD, 1, 0, FETCH), mk(0, LD, 0, 0, DECODE), mk(0, LD, 0, 0, ADDR),
            mk(0, LD, 0, 0, MEM_RD), mk(0, LD, 0, 1, MEM_RD), mk(0, LD, 1, 0, MEM_RD),
            mk(0, LD, 0, 0, WB_MEM), mk(0, LD, 0, 0, FETCH)};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL load step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_store_wait();
    step_t seq[$];
    exp_t  e, o;
    seq = '{mk(0, SD, 0, 0, FETCH), mk(0, SD, 1, 0, FETCH), mk(0, SD, 0, 0, DECODE),
            mk(0, SD, 0, 0, ADDR), mk(0, SD, 0, 0, MEM_WR), mk(0, SD, 1, 0, MEM_WR),
            mk(0, SD, 0, 0, FETCH)};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL store step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_branch();
    step_t seq[$];
    exp_t  e, o;
    seq = '{mk(0, BEQ, 1, 0, FETCH), mk(0, BEQ, 0, 0, DECODE), mk(0, BEQ, 0, 1, BRANCH),
            mk(0, BEQ, 1, 0, FETCH), mk(0, BEQ, 0, 1, DECODE), mk(0, BEQ, 1, 0, BRANCH),
            mk(0, BEQ, 0, 0, FETCH)};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL branch step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t seq[$];
    exp_t  e, o;
    seq = '{mk(0, BEQ, 1, 1, FETCH), mk(0, BEQ, 1, 1, DECODE), mk(0, BEQ, 1, 1, BRANCH),
            mk(0, SD, 1, 1, FETCH), mk(0, SD, 1, 1, DECODE), mk(0, SD, 1, 1, ADDR),
            mk(0, SD, 1, 1, MEM_WR), mk(0, LD, 1, 1, FETCH), mk(0, LD, 1, 1, DECODE),
            mk(0, LD, 1, 1, ADDR), mk(0, LD, 1, 1, MEM_RD), mk(0, LD, 1, 1, WB_MEM),
            mk(0, RTYPE, 0, 0, FETCH)};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL b2b step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_trap();
    step_t seq[$];
    exp_t  e, o;
    seq.push_back(mk(0, BAD, 1, 0, FETCH));
    seq.push_back(mk(0, BAD, 0, 0, DECODE));
    for (int k = 0; k < 12; k++)
      seq.push_back(mk(0, (k < 6) ? BAD : RTYPE, 1'($urandom), 1'($urandom), TRAP));
    seq.push_back(mk(1, RTYPE, 1, 1, TRAP));
    seq.push_back(mk(0, RTYPE, 1, 1, IDLE));
    seq.push_back(mk(0, RTYPE, 0, 0, FETCH));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL trap step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    step_t seq[$];
    exp_t  e, o;
    seq = '{mk(0, SD, 1, 0, FETCH), mk(0, SD, 0, 0, DECODE), mk(0, SD, 0, 0, ADDR),
            mk(0, SD, 0, 0, MEM_WR), mk(1, SD, 0, 0, MEM_WR), mk(0, SD, 0, 0, IDLE),
            mk(0, SD, 0, 0, FETCH)};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk_i);
      o = observe(); e = sb_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL rst_mid step %0d: state got %0d want %0d, word got %h want %h", i, o.st, e.st, o, e);
      else n_pass++;
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype();
    test_addi();
    test_load_wait();
    test_store_wait();
    test_branch();
    test_back_to_back();
    test_trap();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
